// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: fill FSM state type and pseudo-LRU tree helpers shared by icache_sa.
// Tree layout: bit0 is the root; bit1/bit2 select within the low/high way pair.
package icache_sa_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} icache_state_t;

    localparam int PLRU_W = 3;

    function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] tree, input int ways);
        return ways == 4 ? (tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]}) :
               ways == 2 ? {1'b0, tree[0]} : 2'd0;
    endfunction

    // Point every node on the accessed path away from the accessed way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree, input logic [1:0] way,
                                                     input int ways);
        logic [PLRU_W-1:0] n;
        n = tree;
        if (ways == 2) begin
            n[0] = ~way[0];
        end else if (ways == 4) begin
            n[0] = ~way[1];
            if (way[1]) n[2] = ~way[0];
            else n[1] = ~way[0];
        end else begin
            n = '0;
        end
        return n;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// icache_plru: combinational pseudo-LRU tree update and victim selection for one set.
module icache_plru
    import icache_sa_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [PLRU_W-1:0] tree,
    input  logic [1:0]        way,
    output logic [PLRU_W-1:0] next_tree,
    output logic [1:0]        victim
);

    assign next_tree = plru_touch(tree, way, WAYS);
    assign victim    = plru_victim(tree, WAYS);

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with PLRU replacement and block-fill FSM.
// Define ICACHE_CRITICAL_WORD_EN to fill requested-word-first and hit on its capture.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int WOFF  = $clog2(BLKWORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX - WOFF;
    localparam int WB    = WOFF > 0 ? WOFF : 1;
    localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam logic [WB-1:0] WMASK = WB'(BLKWORDS - 1);

    typedef struct packed {
        logic                       valid;
        logic [TAG_W-1:0]           tag;
        logic [BLKWORDS-1:0][31:0]  data;
    } frame_t;

    frame_t                    frames_q [SETS][WAYS];
    logic [PLRU_W-1:0]         plru_q [SETS];
    logic [BLKWORDS-1:0][31:0] buf_q, buf_d;
    icache_state_t             state_q, state_d;
    logic [WB-1:0]             cnt_q, cnt_d;
    logic [31:0]               addr_q, addr_d;

    logic [IDX-1:0]    req_idx, fill_idx, cur_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WB-1:0]     req_woff, fill_woff, start;
    logic              hit, has_inv, idle_hit, crit_hit;
    logic [WW-1:0]     hit_way, inv_way, victim, plru_way;
    logic [PLRU_W-1:0] plru_next;
    logic [1:0]        plru_vic;

    assign req_idx   = imemaddr[IDX+WOFF+1:WOFF+2];
    assign req_tag   = imemaddr[31:IDX+WOFF+2];
    assign req_woff  = WB'(imemaddr[31:2]) & WMASK;
    assign fill_idx  = addr_q[IDX+WOFF+1:WOFF+2];
`ifdef ICACHE_CRITICAL_WORD_EN
    assign start     = WB'(addr_q[31:2]) & WMASK;
    assign crit_hit  = state_q == FILL && !iwait && cnt_q == '0 && imemREN && imemaddr[31:2] == addr_q[31:2];
`else
    assign start     = '0;
    assign crit_hit  = 1'b0;
`endif
    assign fill_woff = (start + cnt_q) & WMASK;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (frames_q[req_idx][w].valid && frames_q[req_idx][w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!frames_q[fill_idx][w].valid) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    // One PLRU instance serves both the IDLE hit update and the WRITE victim choice.
    assign cur_idx  = state_q == IDLE ? req_idx : fill_idx;
    assign victim   = has_inv ? inv_way : WW'(plru_vic);
    assign plru_way = state_q == WRITE ? victim : hit_way;

    icache_plru #(.WAYS(WAYS)) u_plru (
        .tree      (plru_q[cur_idx]),
        .way       (2'(plru_way)),
        .next_tree (plru_next),
        .victim    (plru_vic)
    );

    assign idle_hit = state_q == IDLE && imemREN && hit;
    assign ihit     = idle_hit | crit_hit;
    assign imemload = idle_hit ? frames_q[req_idx][hit_way].data[req_woff] : crit_hit ? iload : '0;
    assign iREN     = state_q == FILL;
    assign iaddr    = iREN ? (addr_q & ~32'(BLKWORDS * 4 - 1)) | (32'(fill_woff) << 2) : imemaddr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (imemREN && !hit) begin
                state_d = FILL;
                cnt_d   = '0;
                addr_d  = imemaddr;
            end
            FILL: if (!iwait) begin
                buf_d[fill_woff] = iload;
                cnt_d            = cnt_q + WB'(1);
                state_d          = cnt_q == WMASK ? WRITE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) frames_q[s][w].valid <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            if (idle_hit || state_q == WRITE) plru_q[cur_idx] <= plru_next;
            if (state_q == WRITE) frames_q[fill_idx][victim] <= {1'b1, addr_q[31:IDX+WOFF+2], buf_q};
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed self-checking bench for icache_sa with a fixed 2-wait-state memory model.
module tb_icache_sa;

`ifdef ICACHE_CRITICAL_WORD_EN
    localparam int BW = 4;
`else
    localparam int BW = 2;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit, iREN, iwait;
    logic [31:0] imemload, iaddr, iload;
    logic [1:0]  wcnt;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        miss;
        logic [31:0] data;
    } vec_t;

    vec_t vt [14];

    always #5 CLK = ~CLK;

    icache_sa #(.SETS(8), .WAYS(2), .BLKWORDS(BW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h11111111 : a == 32'h4 ? 32'h22222222 : {~a[15:0], a[15:0]};
    endfunction

    // Memory holds iwait high for two cycles, then releases for one capture cycle per word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) wcnt <= 2'd2;
        else wcnt <= (iREN && wcnt != 2'd0) ? wcnt - 2'd1 : 2'd2;
    end
    assign iwait = !(iREN && wcnt == 2'd0);
    assign iload = mem(iaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic [31:0] addr, input logic miss, input logic [31:0] exp);
        int k;
        int lat;
        imemREN  = 1'b1;
        imemaddr = addr;
        #1;
        if (!miss) begin
            chk("hit_ihit", 32'(ihit), 32'd1);
            chk("hit_data", imemload, exp);
        end else begin
            chk("miss_ihit", 32'(ihit), 32'd0);
            k   = 0;
            lat = 0;
            while (!ihit && lat < 100) begin
                @(negedge CLK);
                #3;
                lat++;
                if (iREN && !iwait) begin
                    chk("fill_iaddr", iaddr, (addr & ~32'(BW * 4 - 1)) + 32'(4 * k));
                    k++;
                end
            end
            chk("miss_latency", 32'(lat), 32'(2 + 3 * BW));
            chk("fill_words", 32'(k), 32'(BW));
            chk("miss_data", imemload, exp);
        end
        @(negedge CLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        vt[0]  = '{32'h000, 1'b1, mem(32'h000)};
        vt[1]  = '{32'h004, 1'b0, mem(32'h004)};
        vt[2]  = '{32'h040, 1'b1, mem(32'h040)};
        vt[3]  = '{32'h044, 1'b0, mem(32'h044)};
        vt[4]  = '{32'h080, 1'b1, mem(32'h080)};
        vt[5]  = '{32'h040, 1'b0, mem(32'h040)};
        vt[6]  = '{32'h000, 1'b1, mem(32'h000)};
        vt[7]  = '{32'h040, 1'b0, mem(32'h040)};
        vt[8]  = '{32'h000, 1'b0, mem(32'h000)};
        vt[9]  = '{32'h080, 1'b1, mem(32'h080)};
        vt[10] = '{32'h000, 1'b0, mem(32'h000)};
        vt[11] = '{32'h040, 1'b1, mem(32'h040)};
        vt[12] = '{32'h008, 1'b1, mem(32'h008)};
        vt[13] = '{32'h00C, 1'b0, mem(32'h00C)};

        imemREN  = 1'b1;
        imemaddr = 32'h1234;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'h1234);
        @(negedge CLK);
        nRST    = 1'b1;
        imemREN = 1'b0;

`ifdef ICACHE_CRITICAL_WORD_EN
        imemREN  = 1'b1;
        imemaddr = 32'h4;
        #1;
        chk("cw_req_ihit", 32'(ihit), 32'd0);
        k = 0;
        n = 0;
        while (k < 4 && n < 60) begin
            @(negedge CLK);
            #3;
            n++;
            if (iREN && !iwait) begin
                chk("cw_iaddr", iaddr, 32'(4 * ((1 + k) % 4)));
                chk("cw_cap_ihit", 32'(ihit), 32'(k == 0));
                if (k == 0) chk("cw_cap_data", imemload, mem(32'h4));
                k++;
            end else if (iREN) begin
                chk("cw_wait_ihit", 32'(ihit), 32'd0);
            end
        end
        chk("cw_words", 32'(k), 32'd4);
        @(negedge CLK);
        #3;
        chk("cw_write_ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        #3;
        chk("cw_idle_ihit", 32'(ihit), 32'd1);
        chk("cw_idle_data", imemload, mem(32'h4));
        @(negedge CLK);
        #2;
        access(32'hC, 1'b0, mem(32'hC));
        access(32'h0, 1'b0, mem(32'h0));
`else
        for (int i = 0; i < 14; i++) access(vt[i].addr, vt[i].miss, vt[i].data);

        imemREN  = 1'b1;
        imemaddr = 32'h100;
        k = 0;
        n = 0;
        while (k < 2 && n < 40) begin
            @(negedge CLK);
            #3;
            n++;
            if (iREN && !iwait) begin
                chk("mid_iaddr", iaddr, 32'h100 + 32'(4 * k));
                k++;
                imemaddr = 32'h200;
            end
        end
        chk("mid_words", 32'(k), 32'd2);
        repeat (3) @(negedge CLK);
        #3;
        chk("mid_newfill", {31'(iREN), iaddr[0]} == 32'd2 ? iaddr : 32'hFFFFFFFF, 32'h200);
        n = 0;
        while (!ihit && n < 40) begin
            @(negedge CLK);
            #3;
            n++;
        end
        chk("mid_new_data", imemload, mem(32'h200));
        @(negedge CLK);
        #2;
        access(32'h100, 1'b0, mem(32'h100));

        imemaddr = 32'h300;
        repeat (2) @(negedge CLK);
        #3;
        chk("rstfill_iren_before", 32'(iREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstfill_iren_after", 32'(iREN), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        access(32'h300, 1'b1, mem(32'h300));
        access(32'h100, 1'b1, mem(32'h100));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
